// File: rtl/ram_1p_req_adapter.sv
// Request/response front end for a 1-cycle-latency single-port RAM.
// Read data is captured into a small credit-protected FIFO so the host can backpressure responses.
module ram_1p_req_adapter #(
  parameter int unsigned Width    = 32,
  parameter int unsigned Depth    = 128,
  parameter int unsigned RspDepth = 2,
  localparam int unsigned Aw      = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_i,
  output logic             gnt_o,
  input  logic             we_i,
  input  logic [Aw-1:0]    addr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic [Width-1:0] wmask_i,
  output logic             rvalid_o,
  input  logic             rready_i,
  output logic [Width-1:0] rdata_o,
  output logic             ram_req_o,
  output logic             ram_write_o,
  output logic [Aw-1:0]    ram_addr_o,
  output logic [Width-1:0] ram_wdata_o,
  output logic [Width-1:0] ram_wmask_o,
  input  logic [Width-1:0] ram_rdata_i
);

  localparam int unsigned PtrW = (RspDepth > 1) ? $clog2(RspDepth) : 1;
  localparam int unsigned CntW = $clog2(RspDepth + 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(RspDepth - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(RspDepth);
  localparam logic [CntW:0]   DepthC  = (CntW + 1)'(RspDepth);

  logic             rd_pending_q, rd_pending_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [Width-1:0] mem_q [RspDepth];

  logic             push, pop, credit_ok;
  logic [CntW:0]    occ;

  // Explicit wrap so non-power-of-2 depths work.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + PtrW'(1);
  endfunction

  always_comb begin
    rvalid_o  = (cnt_q != '0);
    rdata_o   = rvalid_o ? mem_q[rd_ptr_q] : '0;
    push      = rd_pending_q;
    pop       = rvalid_o & rready_i;
    // In-flight read holds a slot; a same-cycle pop frees one.
    occ       = {1'b0, cnt_q} + {{CntW{1'b0}}, rd_pending_q} - {{CntW{1'b0}}, pop};
    credit_ok = (occ < DepthC);
    gnt_o     = req_i & (we_i | credit_ok);

    rd_pending_d = gnt_o & ~we_i;

    cnt_d = cnt_q;
    if (push && !pop) begin
      cnt_d = cnt_q + CntW'(1);
    end else if (!push && pop) begin
      cnt_d = cnt_q - CntW'(1);
    end

    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
  end

  assign ram_req_o   = gnt_o;
  assign ram_write_o = we_i;
  assign ram_addr_o  = addr_i;
  assign ram_wdata_o = wdata_i;
  assign ram_wmask_o = wmask_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_pending_q <= 1'b0;
      cnt_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
    end else begin
      rd_pending_q <= rd_pending_d;
      cnt_q        <= cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= ram_rdata_i;
    end
  end

  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push && (cnt_q == FullCnt) && !pop));

  a_req_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (req_i && !gnt_o) |=> (req_i && $stable(we_i) && $stable(addr_i) && $stable(wdata_i)));

  a_rdata_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (rvalid_o && !rready_i) |=> $stable(rdata_o));

endmodule

// File: tb/tb_ram_1p_req_adapter.sv
// Randomized + directed bench for ram_1p_req_adapter with a behavioural memory model
// and a response scoreboard checked by an independent monitor.
module tb_ram_1p_req_adapter;

  localparam int unsigned Width    = 32;
  localparam int unsigned Depth    = 128;
  localparam int unsigned RspDepth = 2;
  localparam int unsigned Aw       = 7;

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b0;
  logic             req_i = 1'b0;
  logic             gnt_o;
  logic             we_i = 1'b0;
  logic [Aw-1:0]    addr_i = '0;
  logic [Width-1:0] wdata_i = '0;
  logic [Width-1:0] wmask_i = '0;
  logic             rvalid_o;
  logic             rready_i = 1'b0;
  logic [Width-1:0] rdata_o;
  logic             ram_req_o;
  logic             ram_write_o;
  logic [Aw-1:0]    ram_addr_o;
  logic [Width-1:0] ram_wdata_o;
  logic [Width-1:0] ram_wmask_o;
  logic [Width-1:0] ram_rdata_i = '0;

  ram_1p_req_adapter #(
    .Width   (Width),
    .Depth   (Depth),
    .RspDepth(RspDepth)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .req_i      (req_i),
    .gnt_o      (gnt_o),
    .we_i       (we_i),
    .addr_i     (addr_i),
    .wdata_i    (wdata_i),
    .wmask_i    (wmask_i),
    .rvalid_o   (rvalid_o),
    .rready_i   (rready_i),
    .rdata_o    (rdata_o),
    .ram_req_o  (ram_req_o),
    .ram_write_o(ram_write_o),
    .ram_addr_o (ram_addr_o),
    .ram_wdata_o(ram_wdata_o),
    .ram_wmask_o(ram_wmask_o),
    .ram_rdata_i(ram_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];

  logic [31:0] ram_mem [Depth];  // the RAM behind the adapter, driven via ram_* pins
  logic [31:0] gold    [Depth];  // reference memory, updated from host-side requests

  always @(posedge clk_i) cyc <= cyc + 1;

  always @(posedge clk_i) begin
    if (ram_req_o) begin
      if (ram_write_o) begin
        ram_mem[ram_addr_o] <= (ram_mem[ram_addr_o] & ~ram_wmask_o) | (ram_wdata_o & ram_wmask_o);
      end else begin
        ram_rdata_i <= ram_mem[ram_addr_o];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Monitor: a response is due two cycles after its grant, in order.
  always @(negedge clk_i) begin
    #1;
    if (rst_ni) begin
      logic exp_rv;
      exp_rv = (exp_q.size() > 0) && (exp_q[0].cyc + 2 <= cyc);
      chk("rvalid", {31'b0, rvalid_o}, {31'b0, exp_rv});
      if (exp_rv) begin
        chk("rdata", rdata_o, exp_q[0].data);
        if (rready_i) void'(exp_q.pop_front());
      end else begin
        chk("rdata_idle", rdata_o, 32'h0);
      end
    end
  end

  // One cycle of host activity; returns whether the model expects a grant.
  task automatic step(input logic rq, input logic we, input logic [Aw-1:0] a,
                      input logic [31:0] wd, input logic [31:0] wm, input logic rr,
                      output logic g);
    logic exp_pop;
    logic push_pend;
    exp_t ent;
    req_i = rq; we_i = we; addr_i = a; wdata_i = wd; wmask_i = wm; rready_i = rr;
    @(negedge clk_i);
    exp_pop = rr && (exp_q.size() > 0) && (exp_q[0].cyc + 2 <= cyc);
    g = rq && (we || ((exp_q.size() - int'(exp_pop)) < RspDepth));
    chk("gnt", {31'b0, gnt_o}, {31'b0, g});
    chk("ram_req", {31'b0, ram_req_o}, {31'b0, g});
    push_pend = 1'b0;
    if (g) begin
      chk("ram_write", {31'b0, ram_write_o}, {31'b0, we});
      chk("ram_addr", {25'b0, ram_addr_o}, {25'b0, a});
      if (we) begin
        chk("ram_wdata", ram_wdata_o, wd);
        chk("ram_wmask", ram_wmask_o, wm);
        gold[a] = (gold[a] & ~wm) | (wd & wm);
      end else begin
        push_pend = 1'b1;
        ent.data  = gold[a];
        ent.cyc   = cyc;
      end
    end
    @(posedge clk_i);
    if (push_pend) exp_q.push_back(ent);
    #1;
  endtask

  task automatic wr(input logic [Aw-1:0] a, input logic [31:0] d, input logic [31:0] m,
                    input logic rr);
    logic g;
    step(1'b1, 1'b1, a, d, m, rr, g);
  endtask

  task automatic idle(input int n, input logic rr);
    logic g;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, '0, rr, g);
  endtask

  // Hold a read until granted (bounded).
  task automatic rd_hold(input logic [Aw-1:0] a, input logic rr_first, input int wait_n);
    logic g;
    step(1'b1, 1'b0, a, '0, '0, rr_first, g);
    for (int i = 0; i < wait_n && !g; i++) step(1'b1, 1'b0, a, '0, '0, 1'b1, g);
    if (!g) chk("read_eventually_granted", 32'h0, 32'h1);
  endtask

  initial begin
    logic g;
    logic hold;
    logic rq, we, rr;
    logic [Aw-1:0] a;
    logic [31:0] wd, wm;
    for (int i = 0; i < Depth; i++) begin
      ram_mem[i] = '0;
      gold[i]    = '0;
    end
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;

    // Reset then idle.
    idle(2, 1'b0);

    // Write then read back with rready high.
    wr(7'd5, 32'hDEADBEEF, 32'hFFFFFFFF, 1'b1);
    rd_hold(7'd5, 1'b1, 0);
    idle(3, 1'b1);

    // Preload and back-to-back reads under continuous rready.
    wr(7'd1, 32'h11, 32'hFFFFFFFF, 1'b1);
    wr(7'd2, 32'h22, 32'hFFFFFFFF, 1'b1);
    wr(7'd3, 32'h33, 32'hFFFFFFFF, 1'b1);
    wr(7'd4, 32'h44, 32'hFFFFFFFF, 1'b1);
    for (int i = 1; i <= 4; i++) rd_hold(Aw'(i), 1'b1, 0);
    idle(3, 1'b1);

    // Same with rready low: two reads fill the FIFO, third blocks until a pop.
    step(1'b1, 1'b0, 7'd1, '0, '0, 1'b0, g);
    step(1'b1, 1'b0, 7'd2, '0, '0, 1'b0, g);
    step(1'b1, 1'b0, 7'd3, '0, '0, 1'b0, g);
    step(1'b1, 1'b0, 7'd3, '0, '0, 1'b0, g);
    step(1'b1, 1'b0, 7'd3, '0, '0, 1'b1, g);
    rd_hold(7'd4, 1'b1, 4);
    idle(4, 1'b1);

    // Masked write, issued while the FIFO is full.
    step(1'b1, 1'b0, 7'd1, '0, '0, 1'b0, g);
    step(1'b1, 1'b0, 7'd2, '0, '0, 1'b0, g);
    wr(7'd9, 32'hAAAAAAAA, 32'hFFFFFFFF, 1'b0);
    wr(7'd9, 32'h12345678, 32'h0000FFFF, 1'b0);
    rd_hold(7'd9, 1'b1, 4);
    idle(4, 1'b1);

    // Reset during an in-flight read discards it.
    rd_hold(7'd5, 1'b1, 0);
    #1 rst_ni = 1'b0;
    exp_q.delete();
    idle(2, 1'b1);
    rst_ni = 1'b1;
    idle(3, 1'b1);
    step(1'b1, 1'b0, 7'd1, '0, '0, 1'b0, g);
    step(1'b1, 1'b0, 7'd2, '0, '0, 1'b0, g);
    step(1'b1, 1'b0, 7'd3, '0, '0, 1'b0, g);
    rd_hold(7'd3, 1'b0, 5);
    idle(4, 1'b1);

    // Randomized traffic with small address range to exercise read-after-write.
    hold = 1'b0;
    rq = 0; we = 0; a = '0; wd = '0; wm = '0;
    for (int i = 0; i < 600; i++) begin
      if (!hold) begin
        rq = ($urandom_range(0, 3) != 0);
        we = ($urandom_range(0, 2) == 0);
        a  = Aw'($urandom_range(0, 15));
        wd = $urandom;
        wm = ($urandom_range(0, 1) == 0) ? 32'hFFFFFFFF : $urandom;
      end
      rr = ($urandom_range(0, 2) != 0);
      step(rq, we, a, wd, wm, rr, g);
      hold = rq && !g;
    end
    for (int i = 0; i < 8 && hold; i++) begin
      step(rq, we, a, wd, wm, 1'b1, g);
      hold = !g;
    end
    idle(6, 1'b1);
    chk("scoreboard_drained", exp_q.size(), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ram_1p_req_adapter.md
Name: ram_1p_req_adapter

Overview:
- Front-end stage directly upstream of the generic single-port synchronous RAM (1-cycle read latency, no write response).
- Converts a req/gnt request channel plus a rvalid/rready response channel into the raw RAM strobe interface.
- Captures RAM read data one cycle after issue into a small response FIFO, so consumers can backpressure reads without losing data.
- Used by fetch/LSU-side memory wrappers that cannot guarantee accepting read data in a fixed cycle.

Parameters:
- Width, 32, data width in bits; must match the RAM.
- Depth, 128, RAM word count; Aw = $clog2(Depth) is derived.
- RspDepth, 2, response FIFO entries; must be >= 1. Value 2 sustains one read per cycle under continuous rready_i.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- req_i  in  1  host request valid.
- gnt_o  out  1  request accepted this cycle; combinational.
- we_i  in  1  1 = write, 0 = read.
- addr_i  in  Aw  word address.
- wdata_i  in  Width  write data.
- wmask_i  in  Width  full bit-level write mask.
- rvalid_o  out  1  read response valid (FIFO head).
- rready_i  in  1  host accepts response.
- rdata_o  out  Width  read response data (FIFO head).
- ram_req_o  out  1  RAM request strobe.
- ram_write_o  out  1  RAM write enable.
- ram_addr_o  out  Aw  RAM address.
- ram_wdata_o  out  Width  RAM write data.
- ram_wmask_o  out  Width  RAM write mask.
- ram_rdata_i  in  Width  RAM read data, valid the cycle after a read strobe.

Behaviour:
- State:
  - rd_pending_q (1 bit): a read was issued last cycle.
  - FIFO storage and pointers.
  - cnt_q: FIFO occupancy, 0..RspDepth.
- Reset (async, rst_ni = 0): rd_pending_q = 0, cnt_q = 0, pointers = 0, so rvalid_o = 0. rdata_o is driven 0 while empty. FIFO storage needs no reset.
- pop = rvalid_o & rready_i. Setting rready_i with rvalid_o = 0 has no effect.
- Credit:
  - credit_ok = (cnt_q + rd_pending_q - pop) < RspDepth.
  - Pop frees credit in the same cycle, so there is a combinational path from rready_i to gnt_o.
- Grant:
  - Writes: gnt_o = req_i & we_i. Writes are always accepted and never produce a response.
  - Reads: gnt_o = req_i & ~we_i & credit_ok.
- RAM drive (combinational pass-through):
  - ram_req_o = gnt_o.
  - ram_write_o = we_i.
  - ram_addr_o, ram_wdata_o and ram_wmask_o equal the corresponding inputs.
  - When ram_req_o = 0, the other RAM outputs are don't-care.
- Read pipeline:
  - Cycle T: read granted, so rd_pending_q = 1 in T+1.
  - Cycle T+1: ram_rdata_i is pushed into the FIFO at the end of the cycle.
  - Cycle T+2: rvalid_o = 1 at the earliest.
  - Total latency from grant to rvalid_o is therefore 2 cycles. There is no bypass path.
- FIFO:
  - Push = rd_pending_q. Push and pop in the same cycle leave cnt_q unchanged.
  - Pointers wrap modulo RspDepth. Non-power-of-2 depths must wrap explicitly.
  - Responses are returned strictly in request order.
- Overflow: impossible by construction. The credit check guarantees a push never finds cnt_q = RspDepth unless a pop occurs in the same cycle. Assert !(push & cnt_q == RspDepth & !pop).
- Protocol assertions:
  - While req_i & !gnt_o, the host must hold req_i, we_i, addr_i and wdata_i stable.
  - While rvalid_o & !rready_i, rdata_o stays stable. The design guarantees this.
- Read-after-write: a write granted in cycle T followed by a read granted in T+1 to the same address returns the new data (RAM ordering is preserved; no reordering inside the adapter).
- Reset mid-operation: any in-flight read (rd_pending_q) and all buffered responses are discarded. No response appears after reset deassertion.

Test Plan:
- Reset then idle → gnt_o = 0, rvalid_o = 0, rdata_o = 0, ram_req_o = 0.
- Write addr 5 data 0xDEADBEEF mask all-ones, then read addr 5 with rready_i = 1 → read granted in cycle T, rvalid_o = 1 with rdata_o = 0xDEADBEEF in T+2, for exactly one cycle.
- Back-to-back reads of addr 1, 2, 3, 4 (preloaded 0x11, 0x22, 0x33, 0x44) with rready_i held 1 → a grant every cycle, responses 0x11..0x44 on consecutive cycles.
- Same as above with rready_i = 0 → only 2 reads granted (RspDepth = 2), gnt_o = 0 for the 3rd read, which also gets no ram_req_o. Raise rready_i → 3rd read granted in the same cycle as the first pop; order preserved.
- Write with wmask_i = 0x0000FFFF and data 0x12345678 over 0xAAAAAAAA, then read → 0xAAAA5678. Writes stay granted while the FIFO is full.
- Read granted, then rst_ni pulsed low in T+1 → after release rvalid_o stays 0, cnt_q = 0, and gnt_o resumes normally.
